sdram_read_master: RTL and testbench

Parametrised pipelined Avalon-MM read master between client logic and the SDRAM controller slave port. Supports `readdatavalid`, so multiple reads may be in flight. `waitrequest` and `readdatavalid` are handled independently, including when both are asserted in the same cycle. Returned data lands in an internal response FIFO drained by a valid/ready client port, and credit accounting guarantees the FIFO never overflows.

---
 rtl/sdram_pkg.sv | 17 +
 rtl/sdram_resp_fifo.sv | 65 ++++++
 rtl/sdram_read_master.sv | 118 +++++++++++
 tb/tb_sdram_read_master.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared widths, types and command-slot states for the SDRAM read master
// Purpose: default address/data widths and the typedefs/enums used by
//          sdram_read_master and its testbench.
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 25;
    localparam int SDRAM_DATA_W = 32;

    typedef logic [SDRAM_ADDR_W-1:0] sdram_addr_t;
    typedef logic [SDRAM_DATA_W-1:0] sdram_data_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } cmd_state_e;

endpackage

// File: rtl/sdram_resp_fifo.sv
// rtl/sdram_resp_fifo.sv - response FIFO with registered storage and count/full/empty flags
// Purpose: buffers read data returned by the slave until the client pops it.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   push, push_data    write one word (ignored when full)
//   pop                remove the head word (ignored when empty)
//   head_data          current head word, driven from registered storage
//   count, full, empty occupancy and flags
module sdram_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    // Head is read straight from the storage registers; a word written while
    // empty only becomes visible once count has updated on the next cycle.
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_read_master.sv
// rtl/sdram_read_master.sv - pipelined Avalon-MM read master with credit-gated response FIFO
// Purpose: accepts client read requests, issues them to the SDRAM controller
//          slave with a single command slot, and buffers the returned data.
// Ports:
//   clk, reset_n                         clock, asynchronous active-low reset
//   req_valid, req_ready, req_address    client request handshake
//   resp_valid, resp_ready, resp_data    client response handshake (FIFO head)
//   protocol_err                         sticky: readdatavalid with nothing in flight
//   avm_m0_address, avm_m0_read_n        registered Avalon command outputs
//   avm_m0_readdata, avm_m0_waitrequest,
//   avm_m0_readdatavalid                 Avalon slave responses
module sdram_read_master
    import sdram_pkg::*;
#(
    parameter int ADDR_W      = SDRAM_ADDR_W,
    parameter int DATA_W      = SDRAM_DATA_W,
    parameter int MAX_PENDING = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_address,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              protocol_err,
    output logic [ADDR_W-1:0] avm_m0_address,
    output logic              avm_m0_read_n,
    input  logic [DATA_W-1:0] avm_m0_readdata,
    input  logic              avm_m0_waitrequest,
    input  logic              avm_m0_readdatavalid
);

    localparam int CW = $clog2(MAX_PENDING) + 1;

    cmd_state_e    state;
    cmd_state_e    state_nxt;
    logic [CW-1:0] credits;
    logic [CW-1:0] inflight;
    logic          accept;
    logic          pop;
    logic          complete;
    logic          rdv_ok;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_unused;

    // A new request may enter only when a credit is free and the command
    // slot is either empty or being vacated this very cycle.
    assign req_ready = (credits < CW'(MAX_PENDING)) &&
                       ((state == IDLE) || !avm_m0_waitrequest);
    assign accept    = req_valid & req_ready;
    assign complete  = (state == ISSUE) & ~avm_m0_waitrequest;
    assign pop       = resp_valid & resp_ready;
    // A zero-latency slave may return data in the completion cycle itself.
    assign rdv_ok    = avm_m0_readdatavalid & ((inflight != '0) | complete);

    assign resp_valid  = ~fifo_empty;
    // Credits already bound FIFO occupancy; the flags are kept for visibility.
    assign fifo_unused = ^{fifo_count, fifo_full};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   if (complete) state_nxt = accept ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            avm_m0_read_n  <= 1'b1;
            avm_m0_address <= '0;
            credits        <= '0;
            inflight       <= '0;
            protocol_err   <= 1'b0;
        end else begin
            state         <= state_nxt;
            avm_m0_read_n <= (state_nxt != ISSUE);
            if (accept) begin
                avm_m0_address <= req_address;
            end
            case ({accept, pop})
                2'b10:   credits <= credits + CW'(1);
                2'b01:   credits <= credits - CW'(1);
                default: credits <= credits;
            endcase
            case ({complete, rdv_ok})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
            if (avm_m0_readdatavalid && !rdv_ok) begin
                protocol_err <= 1'b1;
            end
        end
    end

    sdram_resp_fifo #(
        .DEPTH (MAX_PENDING),
        .WIDTH (DATA_W)
    ) u_resp_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (rdv_ok),
        .push_data (avm_m0_readdata),
        .pop       (pop),
        .head_data (resp_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_sdram_read_master.sv
// tb/tb_sdram_read_master.sv - scoreboard testbench for sdram_read_master with a behavioural Avalon slave
module tb_sdram_read_master;
    import sdram_pkg::*;

    localparam int MAXP = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    sdram_addr_t req_address = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    sdram_data_t resp_data;
    logic        protocol_err;
    sdram_addr_t avm_m0_address;
    logic        avm_m0_read_n;
    sdram_data_t avm_m0_readdata = '0;
    logic        avm_m0_waitrequest = 1'b0;
    logic        avm_m0_readdatavalid = 1'b0;

    always #5 clk = ~clk;

    sdram_read_master #(
        .ADDR_W      (SDRAM_ADDR_W),
        .DATA_W      (SDRAM_DATA_W),
        .MAX_PENDING (MAXP)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_address          (req_address),
        .resp_valid           (resp_valid),
        .resp_ready           (resp_ready),
        .resp_data            (resp_data),
        .protocol_err         (protocol_err),
        .avm_m0_address       (avm_m0_address),
        .avm_m0_read_n        (avm_m0_read_n),
        .avm_m0_readdata      (avm_m0_readdata),
        .avm_m0_waitrequest   (avm_m0_waitrequest),
        .avm_m0_readdatavalid (avm_m0_readdatavalid)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    // Memory contents as seen by the slave: every word address has a fixed value.
    function automatic sdram_data_t hash(input sdram_addr_t a);
        return {a[6:0], a} ^ 32'hA5C3_0F1E;
    endfunction

    sdram_addr_t addr_q[$];   // accepted, not yet completed on the bus
    sdram_data_t exp_q[$];    // expected responses in request order
    sdram_data_t rd_q[$];     // slave data waiting to be returned
    int          rt_q[$];     // cycle at which each slave word is returned
    int          last_rt = 0;

    int          wait_pct = 0, lat_min = 1, lat_max = 1, reqv_pct = 0, rr_pct = 0;
    bit          inject_spurious = 0;
    bit          fix_addr_en = 0;
    sdram_addr_t fix_addr = '0;
    int          model_credits = 0, n_acc = 0, n_cmp = 0;
    bit          prev_hold = 0;
    sdram_addr_t held_addr = '0;

    task automatic step();
        int lat, rt;
        sdram_addr_t a;
        @(negedge clk);
        avm_m0_waitrequest = (int'($urandom_range(99)) < wait_pct);
        if (rt_q.size() > 0 && rt_q[0] <= cyc) begin
            avm_m0_readdatavalid = 1'b1;
            avm_m0_readdata      = rd_q.pop_front();
            void'(rt_q.pop_front());
        end else if (inject_spurious) begin
            avm_m0_readdatavalid = 1'b1;
            avm_m0_readdata      = 32'hBAD0_BAD0;
            inject_spurious      = 0;
        end else begin
            avm_m0_readdatavalid = 1'b0;
            avm_m0_readdata      = $urandom;
        end
        if (!avm_m0_read_n) begin
            if (prev_hold) chk(avm_m0_address == held_addr, "addr_stable", avm_m0_address, held_addr);
            if (avm_m0_waitrequest) begin
                prev_hold = 1;
                held_addr = avm_m0_address;
            end else begin
                prev_hold = 0;
                n_cmp++;
                if (addr_q.size() == 0) chk(0, "unexpected_cmd", avm_m0_address, 0);
                else begin
                    a = addr_q.pop_front();
                    chk(avm_m0_address == a, "cmd_addr", avm_m0_address, a);
                end
                lat = int'($urandom_range(lat_max, lat_min));
                rt  = cyc + lat;
                if (rt <= last_rt) rt = last_rt + 1;
                last_rt = rt;
                rt_q.push_back(rt);
                rd_q.push_back(hash(avm_m0_address));
            end
        end else begin
            if (prev_hold) chk(0, "read_dropped_while_stalled", 1, 0);
            prev_hold = 0;
        end
        req_valid   = (int'($urandom_range(99)) < reqv_pct);
        req_address = fix_addr_en ? fix_addr : sdram_addr_t'($urandom);
        resp_ready  = (int'($urandom_range(99)) < rr_pct);
        #1;
        if (model_credits >= MAXP) chk(!req_ready, "req_ready_at_credit_limit", req_ready, 0);
        if (req_valid && req_ready) begin
            addr_q.push_back(req_address);
            exp_q.push_back(hash(req_address));
            model_credits++;
            n_acc++;
        end
        if (resp_valid && resp_ready) model_credits--;
    endtask

    task automatic drain();
        rr_pct   = 100;
        reqv_pct = 0;
        wait_pct = 0;
        for (int i = 0; i < 300 && (exp_q.size() > 0 || rt_q.size() > 0 || addr_q.size() > 0); i++) step();
        chk(exp_q.size() == 0, "drain_complete", exp_q.size(), 0);
        chk(!resp_valid, "fifo_empty_after_drain", resp_valid, 0);
    endtask

    // Response monitor: pops the scoreboard whenever the client takes a word.
    always @(negedge clk) begin
        sdram_data_t e;
        #2;
        if (reset_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) chk(0, "unexpected_resp", resp_data, 0);
            else begin
                e = exp_q.pop_front();
                chk(resp_data == e, "resp_data", resp_data, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, c0;
        // reset values
        repeat (2) @(negedge clk);
        #1;
        chk(avm_m0_read_n == 1'b1, "rst_read_n", avm_m0_read_n, 1);
        chk(avm_m0_address == '0, "rst_address", avm_m0_address, 0);
        chk(!resp_valid, "rst_resp_valid", resp_valid, 0);
        chk(resp_data == '0, "rst_resp_data", resp_data, 0);
        chk(!protocol_err, "rst_protocol_err", protocol_err, 0);
        reset_n = 1'b1;
        step();
        chk(req_ready, "ready_after_reset", req_ready, 1);

        // single read, slave latency 2
        wait_pct = 0; lat_min = 2; lat_max = 2; rr_pct = 0;
        fix_addr_en = 1; fix_addr = 25'h0000123; reqv_pct = 100;
        a0 = n_acc;
        step();
        reqv_pct = 0;
        chk(n_acc - a0 == 1, "single_accept", n_acc - a0, 1);
        step();
        chk(!avm_m0_read_n, "single_read_n_n1", avm_m0_read_n, 0);
        step();
        chk(avm_m0_read_n, "single_read_n_n2", avm_m0_read_n, 1);
        step();
        chk(!resp_valid, "single_resp_valid_n3", resp_valid, 0);
        step();
        chk(resp_valid, "single_resp_valid_n4", resp_valid, 1);
        chk(resp_data == hash(25'h0000123), "single_resp_data", resp_data, hash(25'h0000123));
        drain();

        // waitrequest held for three cycles
        fix_addr = 25'h0ABCDE; reqv_pct = 100; wait_pct = 0;
        step();
        reqv_pct = 0; wait_pct = 100; c0 = n_cmp;
        repeat (3) begin
            step();
            chk(!req_ready, "stall_req_ready", req_ready, 0);
            chk(!avm_m0_read_n, "stall_read_n", avm_m0_read_n, 0);
        end
        wait_pct = 0;
        step();
        chk(n_cmp == c0 + 1, "stall_one_completion", n_cmp - c0, 1);
        step();
        chk(avm_m0_read_n, "stall_idle_after", avm_m0_read_n, 1);
        drain();

        // burst of 8 with the client not popping
        fix_addr_en = 0; lat_min = 1; lat_max = 3; rr_pct = 0; reqv_pct = 100;
        a0 = n_acc;
        repeat (8) step();
        chk(n_acc - a0 == MAXP, "burst_accepts_capped", n_acc - a0, MAXP);
        chk(!req_ready, "burst_req_ready_low", req_ready, 0);
        chk(resp_valid, "burst_resp_buffered", resp_valid, 1);
        rr_pct = 100;
        for (int i = 0; i < 100 && (n_acc - a0) < 8; i++) step();
        chk(n_acc - a0 == 8, "burst_all_admitted", n_acc - a0, 8);
        drain();

        // spurious readdatavalid with nothing in flight
        inject_spurious = 1;
        step();
        step();
        chk(protocol_err, "proto_err_set", protocol_err, 1);
        chk(!resp_valid, "spurious_dropped", resp_valid, 0);

        // randomized traffic, including waitrequest and readdatavalid together
        wait_pct = 30; lat_min = 1; lat_max = 5; reqv_pct = 60; rr_pct = 60;
        repeat (400) step();
        drain();
        chk(protocol_err, "proto_err_sticky", protocol_err, 1);

        // reset with three reads in flight
        wait_pct = 0; lat_min = 8; lat_max = 8; rr_pct = 0; reqv_pct = 100;
        repeat (3) step();
        reqv_pct = 0;
        repeat (2) step();
        @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk(avm_m0_read_n == 1'b1, "midrst_read_n", avm_m0_read_n, 1);
        chk(avm_m0_address == '0, "midrst_address", avm_m0_address, 0);
        chk(!resp_valid, "midrst_resp_valid", resp_valid, 0);
        chk(!protocol_err, "midrst_protocol_err", protocol_err, 0);
        addr_q.delete(); exp_q.delete(); rt_q.delete(); rd_q.delete();
        model_credits = 0; prev_hold = 0;
        avm_m0_readdatavalid = 1'b0;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        step();
        chk(req_ready, "postrst_req_ready", req_ready, 1);
        chk(!resp_valid, "postrst_resp_valid", resp_valid, 0);

        wait_pct = 20; lat_min = 1; lat_max = 4; reqv_pct = 70; rr_pct = 80;
        repeat (150) step();
        drain();
        chk(!protocol_err, "postrst_no_proto_err", protocol_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
